rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Writeback scheduler for the 32x32 register file. The register file has a single write port, and two producers compete for it. The in-order ALU pipeline writes back every cycle it has a result. The long-latency unit (load/store, multiply/divide) returns results at arbitrary times.

This block does three jobs:
- arbitrates the write port, with starvation protection for the long-latency unit;
- registers the winning write onto the register file's write port;
- keeps a scoreboard of registers with pending long-latency results, so the issue stage can detect RAW/WAW hazards.

## Interface

Parameters:
- XLEN, 32, data width of writeback values and register file
- STARVE_LIMIT, 4, consecutive refused cycles of a pending long-unit result before the ALU pipeline is frozen; legal range 1..15

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- alu_wb_valid  in  1  ALU pipeline has a result this cycle
- alu_wb_rd  in  5  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- mu_wb_valid  in  1  long unit has a result; must be held with rd/data stable until accepted
- mu_wb_rd  in  5  long-unit destination register
- mu_wb_data  in  XLEN  long-unit result
- mu_wb_ready  out  1  combinational; long-unit result accepted this cycle when valid and ready are both high
- iss_long_valid  in  1  issue stage dispatches a long-latency op this cycle
- iss_long_rd  in  5  destination of that op
- iss_rs1, iss_rs2, iss_rd  in  5 each  operands of the instruction being issued
- iss_hazard  out  1  combinational; busy[iss_rs1] or busy[iss_rs2] or busy[iss_rd]
- alu_stall  out  1  registered; freeze the ALU pipeline, which holds the alu_wb_* signals stable
- rf_wr  out  1  registered write enable to the register file
- rf_addr_wr  out  5  registered write address
- rf_din  out  XLEN  registered write data
- sb_busy  out  32  registered scoreboard vector; bit 0 is always 0

## Operation

- The FSM has two states: NORMAL and DRAIN.
  - alu_stall = 1 exactly when the state is DRAIN.
- Grant rules:
  - An ALU request is live when alu_wb_valid=1 and alu_wb_rd!=0.
  - In NORMAL: the ALU wins whenever its request is live. Otherwise, mu_wb_ready=1.
  - In DRAIN: mu_wb_ready=1 unconditionally. A live ALU request is not written; the frozen pipeline re-presents it.
  - mu_wb_ready=0 while reset=1.
- Writes to x0:
  - An ALU write to rd=0 is dropped and frees the slot.
  - A long-unit result with rd=0 is accepted (handshake completes) but rf_wr stays 0.
- Starvation counter (4 bits):
  - Increments each cycle that mu_wb_valid=1 and mu_wb_ready=0.
  - Clears on any long-unit acceptance, and whenever mu_wb_valid=0.
- FSM transitions:
  - NORMAL -> DRAIN at the edge where the counter would reach STARVE_LIMIT.
  - DRAIN -> NORMAL on acceptance, or if mu_wb_valid is 0 (protocol violation; exit without writing). The counter clears on exit.
- Scoreboard:
  - iss_long_valid with iss_long_rd!=0 sets busy[iss_long_rd].
  - Long-unit acceptance clears busy[mu_wb_rd].
  - Set and clear of the same register in the same cycle: the set wins.
  - Accepting a result for a non-busy register still writes it; busy is unchanged.
- iss_hazard is computed from registered sb_busy only. A clear in cycle N removes the hazard in cycle N+1.

## Timing

- Reset (synchronous) clears: rf_wr=0, rf_addr_wr=0, rf_din=0, alu_stall=0, sb_busy=0, counter=0, state=NORMAL. Reset mid-DRAIN abandons the pending grant.
- Write latency:
  - A grant in cycle N appears on rf_* in cycle N+1 with rf_wr=1.
  - The register file commits it on the falling edge within cycle N+1.
  - rf_wr=0 in any cycle following a cycle with no grant.
- Starvation example (STARVE_LIMIT=4), with the ALU live every cycle and mu_wb_valid rising in cycle 0:

  | Cycle | Event |
  |---|---|
  | 0-3 | Long unit refused (counter 1..4) |
  | 4 | state=DRAIN, alu_stall=1, mu_wb_ready=1, accepted |
  | 5 | NORMAL, alu_stall=0, rf_* carries the long-unit write |
  | 6 | rf_* carries the held ALU write |

- Worst-case long-unit wait under continuous ALU traffic: STARVE_LIMIT+1 cycles.

## Test plan

- **Reset:** reset=1 for 2 cycles with random inputs -> all outputs 0, sb_busy=0, mu_wb_ready=0; release -> NORMAL.
- **Plain ALU writes:** alu_wb_valid=1, rd=5, data=0xDEADBEEF in cycle N -> rf_wr=1, rf_addr_wr=5, rf_din=0xDEADBEEF in cycle N+1. ALU write with rd=0 -> rf_wr=0 and mu_wb_ready=1 in the same cycle.
- **Scoreboard:**
  - iss_long_valid with rd=7 -> sb_busy[7]=1 next cycle; iss_rs1=7 -> iss_hazard=1.
  - Long-unit result rd=7 data=0x1234 with the ALU idle -> accepted at once; sb_busy[7]=0 and iss_hazard=0 the following cycle; rf write of 0x1234 to 7.
- **Starvation:** STARVE_LIMIT=4, ALU live every cycle (rd=3), long-unit result rd=9 pending from cycle 0 -> timing exactly as in the Timing example; the ALU write to 3 is neither lost nor duplicated.
- **Simultaneous events:** in one cycle, iss_long_valid rd=9 and acceptance of a long-unit result rd=9 -> sb_busy[9]=1 afterwards. Dispatch with rd=0 -> sb_busy stays 0.
- **Reset during DRAIN:** assert reset in the cycle alu_stall=1 -> next cycle alu_stall=0, rf_wr=0, sb_busy=0, counter=0; the long unit is re-arbitrated from NORMAL after release.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: arbitrates the single register-file write port between the
// ALU pipeline and the long-latency unit, and tracks pending long-unit destinations.
module rf_wb_scheduler #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            mu_wb_valid,
    input  logic [4:0]      mu_wb_rd,
    input  logic [XLEN-1:0] mu_wb_data,
    output logic            mu_wb_ready,
    input  logic            iss_long_valid,
    input  logic [4:0]      iss_long_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    output logic            iss_hazard,
    output logic            alu_stall,
    output logic            rf_wr,
    output logic [4:0]      rf_addr_wr,
    output logic [XLEN-1:0] rf_din,
    output logic [31:0]     sb_busy
);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state;
    logic [3:0]      starve_cnt;
    logic            alu_live;
    logic            alu_grant;
    logic            mu_accept;
    logic            grant_wr;
    logic [4:0]      grant_addr;
    logic [XLEN-1:0] grant_data;
    logic [31:0]     busy_next;

    assign alu_live    = alu_wb_valid && (alu_wb_rd != 5'd0);
    assign mu_wb_ready = !reset && ((state == DRAIN) || !alu_live);
    assign mu_accept   = mu_wb_valid && mu_wb_ready;
    assign alu_grant   = !reset && (state == NORMAL) && alu_live;
    assign iss_hazard  = sb_busy[iss_rs1] | sb_busy[iss_rs2] | sb_busy[iss_rd];

    // A long-unit result for x0 completes its handshake but never reaches the port.
    always_comb begin
        grant_wr   = 1'b0;
        grant_addr = mu_wb_rd;
        grant_data = mu_wb_data;
        if (alu_grant) begin
            grant_wr   = 1'b1;
            grant_addr = alu_wb_rd;
            grant_data = alu_wb_data;
        end else if (mu_accept && (mu_wb_rd != 5'd0)) begin
            grant_wr = 1'b1;
        end
    end

    // Clear is applied before set so a same-cycle dispatch keeps the register busy.
    always_comb begin
        busy_next = sb_busy;
        if (mu_accept) begin
            busy_next[mu_wb_rd] = 1'b0;
        end
        if (iss_long_valid && (iss_long_rd != 5'd0)) begin
            busy_next[iss_long_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= 4'd0;
            alu_stall  <= 1'b0;
            rf_wr      <= 1'b0;
            rf_addr_wr <= 5'd0;
            rf_din     <= '0;
            sb_busy    <= 32'd0;
        end else begin
            rf_wr   <= grant_wr;
            sb_busy <= busy_next;
            if (grant_wr) begin
                rf_addr_wr <= grant_addr;
                rf_din     <= grant_data;
            end
            case (state)
                NORMAL: begin
                    if (mu_wb_valid && !mu_wb_ready) begin
                        starve_cnt <= starve_cnt + 4'd1;
                        if (starve_cnt + 4'd1 == LIMIT) begin
                            state     <= DRAIN;
                            alu_stall <= 1'b1;
                        end
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                // Long unit always wins here, so DRAIN lasts exactly one cycle.
                DRAIN: begin
                    state      <= NORMAL;
                    alu_stall  <= 1'b0;
                    starve_cnt <= 4'd0;
                end
                default: begin
                    state      <= NORMAL;
                    alu_stall  <= 1'b0;
                    starve_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios followed by random
// traffic, all compared against a cycle-count based reference model.
module tb_rf_wb_scheduler;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk;
    logic            reset;
    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            mu_wb_valid;
    logic [4:0]      mu_wb_rd;
    logic [XLEN-1:0] mu_wb_data;
    logic            mu_wb_ready;
    logic            iss_long_valid;
    logic [4:0]      iss_long_rd;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic [4:0]      iss_rd;
    logic            iss_hazard;
    logic            alu_stall;
    logic            rf_wr;
    logic [4:0]      rf_addr_wr;
    logic [XLEN-1:0] rf_din;
    logic [31:0]     sb_busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: how long the pending long-unit result has waited,
    // the expected port write, and the set of registers awaiting a long result.
    int          wait_cnt;
    logic        m_rf_wr;
    logic [4:0]  m_rf_addr;
    logic [31:0] m_rf_din;
    logic        m_stall;
    logic        m_accept;
    logic [31:0] m_busy;

    rf_wb_scheduler #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_rd      (alu_wb_rd),
        .alu_wb_data    (alu_wb_data),
        .mu_wb_valid    (mu_wb_valid),
        .mu_wb_rd       (mu_wb_rd),
        .mu_wb_data     (mu_wb_data),
        .mu_wb_ready    (mu_wb_ready),
        .iss_long_valid (iss_long_valid),
        .iss_long_rd    (iss_long_rd),
        .iss_rs1        (iss_rs1),
        .iss_rs2        (iss_rs2),
        .iss_rd         (iss_rd),
        .iss_hazard     (iss_hazard),
        .alu_stall      (alu_stall),
        .rf_wr          (rf_wr),
        .rf_addr_wr     (rf_addr_wr),
        .rf_din         (rf_din),
        .sb_busy        (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The long unit gets the port when the ALU has nothing live or it has waited LIMIT cycles.
    function automatic logic expectedReady();
        logic live;
        live = alu_wb_valid && (alu_wb_rd != 5'd0);
        if (reset) return 1'b0;
        return !live || (wait_cnt >= LIMIT);
    endfunction

    task automatic modelStep();
        logic live;
        logic mu_first;
        if (reset) begin
            wait_cnt = 0;
            m_rf_wr  = 1'b0;
            m_rf_addr = 5'd0;
            m_rf_din = 32'd0;
            m_stall  = 1'b0;
            m_accept = 1'b0;
            m_busy   = 32'd0;
        end else begin
            live     = alu_wb_valid && (alu_wb_rd != 5'd0);
            mu_first = (wait_cnt >= LIMIT);
            m_accept = mu_wb_valid && (!live || mu_first);
            if (live && !mu_first) begin
                m_rf_wr = 1'b1; m_rf_addr = alu_wb_rd; m_rf_din = alu_wb_data;
            end else if (m_accept && (mu_wb_rd != 5'd0)) begin
                m_rf_wr = 1'b1; m_rf_addr = mu_wb_rd; m_rf_din = mu_wb_data;
            end else begin
                m_rf_wr = 1'b0;
            end
            if (m_accept) m_busy[mu_wb_rd] = 1'b0;
            if (iss_long_valid && (iss_long_rd != 5'd0)) m_busy[iss_long_rd] = 1'b1;
            wait_cnt = (!mu_wb_valid || m_accept) ? 0 : wait_cnt + 1;
            m_stall  = (wait_cnt >= LIMIT);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_rf_wr"}, 32'(rf_wr), 32'(m_rf_wr));
        if (m_rf_wr) begin
            checkValue({tag, "_rf_addr"}, 32'(rf_addr_wr), 32'(m_rf_addr));
            checkValue({tag, "_rf_din"}, rf_din, m_rf_din);
        end
        checkValue({tag, "_stall"}, 32'(alu_stall), 32'(m_stall));
        checkValue({tag, "_busy"}, sb_busy, m_busy);
        checkValue({tag, "_ready"}, 32'(mu_wb_ready), 32'(expectedReady()));
        checkValue({tag, "_hazard"}, 32'(iss_hazard),
                   32'(m_busy[iss_rs1] | m_busy[iss_rs2] | m_busy[iss_rd]));
    endtask

    // One clock: compare at the falling edge, advance the model, land just after the rising edge.
    task automatic applyStimulus(input string tag);
        @(negedge clk);
        checkOutput(tag);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = '0;
        mu_wb_valid = 1'b0; mu_wb_rd = 5'd0; mu_wb_data = '0;
        iss_long_valid = 1'b0; iss_long_rd = 5'd0;
        iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'($urandom); alu_wb_data = $urandom;
        mu_wb_valid = 1'b1; mu_wb_rd = 5'($urandom); iss_long_valid = 1'b1; iss_long_rd = 5'($urandom);
        @(negedge clk);
        modelStep();
        @(posedge clk);
        #1;
        applyStimulus("reset");
        checkValue("reset_rf_wr", 32'(rf_wr), 32'd0);
        checkValue("reset_busy", sb_busy, 32'd0);
        checkValue("reset_ready", 32'(mu_wb_ready), 32'd0);
        reset = 1'b0;
        setIdle();

        $display("[TB] plain ALU writes");
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        applyStimulus("alu5");
        setIdle();
        checkValue("alu5_wr", 32'(rf_wr), 32'd1);
        checkValue("alu5_addr", 32'(rf_addr_wr), 32'd5);
        checkValue("alu5_din", rf_din, 32'hDEADBEEF);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h5555;
        #1 checkValue("alu0_ready", 32'(mu_wb_ready), 32'd1);
        applyStimulus("alu0");
        setIdle();
        checkValue("alu0_wr", 32'(rf_wr), 32'd0);

        $display("[TB] scoreboard");
        iss_long_valid = 1'b1; iss_long_rd = 5'd7;
        applyStimulus("disp7");
        setIdle();
        iss_rs1 = 5'd7;
        #1 checkValue("disp7_busy", 32'(sb_busy[7]), 32'd1);
        checkValue("disp7_hazard", 32'(iss_hazard), 32'd1);
        mu_wb_valid = 1'b1; mu_wb_rd = 5'd7; mu_wb_data = 32'h1234;
        #1 checkValue("mu7_ready", 32'(mu_wb_ready), 32'd1);
        applyStimulus("mu7");
        mu_wb_valid = 1'b0;
        #1 checkValue("mu7_busy", 32'(sb_busy[7]), 32'd0);
        checkValue("mu7_hazard", 32'(iss_hazard), 32'd0);
        checkValue("mu7_wr", 32'(rf_wr), 32'd1);
        checkValue("mu7_addr", 32'(rf_addr_wr), 32'd7);
        checkValue("mu7_din", rf_din, 32'h1234);
        setIdle();

        $display("[TB] starvation");
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3;
        mu_wb_valid = 1'b1; mu_wb_rd = 5'd9; mu_wb_data = 32'h99;
        for (int c = 0; c < 4; c++) begin
            alu_wb_data = 32'hA0 + 32'(c);
            #1 checkValue("starve_refused", 32'(mu_wb_ready), 32'd0);
            checkValue("starve_nostall", 32'(alu_stall), 32'd0);
            applyStimulus("starve");
        end
        alu_wb_data = 32'hA4;
        #1 checkValue("drain_stall", 32'(alu_stall), 32'd1);
        checkValue("drain_ready", 32'(mu_wb_ready), 32'd1);
        applyStimulus("drain");
        mu_wb_valid = 1'b0;
        #1 checkValue("post_stall", 32'(alu_stall), 32'd0);
        checkValue("post_mu_wr", 32'(rf_wr), 32'd1);
        checkValue("post_mu_addr", 32'(rf_addr_wr), 32'd9);
        checkValue("post_mu_din", rf_din, 32'h99);
        applyStimulus("post");
        alu_wb_valid = 1'b0;
        #1 checkValue("held_alu_addr", 32'(rf_addr_wr), 32'd3);
        checkValue("held_alu_din", rf_din, 32'hA4);
        applyStimulus("held");
        checkValue("no_dup_wr", 32'(rf_wr), 32'd0);
        setIdle();

        $display("[TB] simultaneous set and clear");
        iss_long_valid = 1'b1; iss_long_rd = 5'd9;
        mu_wb_valid = 1'b1; mu_wb_rd = 5'd9; mu_wb_data = 32'h77;
        applyStimulus("simul");
        setIdle();
        checkValue("simul_busy9", 32'(sb_busy[9]), 32'd1);
        iss_long_valid = 1'b1; iss_long_rd = 5'd0;
        applyStimulus("disp0");
        setIdle();
        checkValue("disp0_busy", sb_busy, 32'h0000_0200);

        $display("[TB] reset during drain");
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'hB0;
        mu_wb_valid = 1'b1; mu_wb_rd = 5'd12; mu_wb_data = 32'hC0;
        iss_long_valid = 1'b1; iss_long_rd = 5'd12;
        applyStimulus("rd_pre");
        iss_long_valid = 1'b0;
        for (int c = 1; c < 4; c++) applyStimulus("rd_pre");
        #1 checkValue("rd_stall", 32'(alu_stall), 32'd1);
        reset = 1'b1;
        applyStimulus("rd_reset");
        reset = 1'b0;
        #1 checkValue("rd_stall_clr", 32'(alu_stall), 32'd0);
        checkValue("rd_wr_clr", 32'(rf_wr), 32'd0);
        checkValue("rd_busy_clr", sb_busy, 32'd0);
        for (int c = 0; c < 4; c++) begin
            #1 checkValue("rd_rearb_refused", 32'(mu_wb_ready), 32'd0);
            applyStimulus("rd_rearb");
        end
        #1 checkValue("rd_rearb_stall", 32'(alu_stall), 32'd1);
        checkValue("rd_rearb_ready", 32'(mu_wb_ready), 32'd1);
        applyStimulus("rd_rearb");
        setIdle();
        applyStimulus("rd_tail");

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            if (!m_stall) begin
                alu_wb_valid = ($urandom_range(0, 3) != 0);
                alu_wb_rd    = 5'($urandom_range(0, 7));
                alu_wb_data  = $urandom;
            end
            if (!mu_wb_valid || m_accept) begin
                mu_wb_valid = ($urandom_range(0, 2) == 0);
                mu_wb_rd    = 5'($urandom_range(0, 7));
                mu_wb_data  = $urandom;
            end
            iss_long_valid = ($urandom_range(0, 3) == 0);
            iss_long_rd    = 5'($urandom_range(0, 7));
            iss_rs1 = 5'($urandom_range(0, 7));
            iss_rs2 = 5'($urandom_range(0, 7));
            iss_rd  = 5'($urandom_range(0, 7));
            applyStimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
